// File: rtl/mem_resp_pkg.sv
// Shared types for the wait-state memory responder.
// The byte-lane field of the latched request exists only when MEM_RESP_BYTE_EN is defined.
package mem_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic                  we;
    logic [31:0]           addr;
    logic [31:0]           wdata;
`ifdef MEM_RESP_BYTE_EN
    logic [WORD_BYTES-1:0] be;
`endif
  } mem_req_t;

endpackage

// File: rtl/mem_resp_array.sv
// Word storage for mem_responder: synchronous byte-lane write, registered read.
// The read register clears on reset and on a rejected access so rdata reads 0 with err.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [WORD_BYTES-1:0] wr_be_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  rd_en_i,
  input  logic                  rd_clr_i,
  input  logic [AW-1:0]         idx_i,
  output logic [31:0]           rd_data_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (wr_be_i[i]) mem_q[idx_i][8*i +: 8] <= wr_data_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_clr_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mem_responder.sv
// Data-memory target with a req/ready handshake and WAIT_CYCLES wait states.
// Optional byte-lane store enables are compiled in with MEM_RESP_BYTE_EN.
//
//  state | meaning
//  IDLE  | waiting for req; accepts and latches the request
//  WAIT  | counting down wait states on the latched request
//  RESP  | ready (and err if rejected) high for this one cycle
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
`ifdef MEM_RESP_BYTE_EN
  input  logic [WORD_BYTES-1:0] be,
`endif
  output logic                  ready,
  output logic [31:0]           rdata,
  output logic                  err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_state_t state_q;
  logic [3:0]  cnt_q;
  mem_req_t    req_q;
  mem_req_t    live_req;
  mem_req_t    req_d;
  logic        ready_q;
  logic        err_q;

  logic                  enter_resp;
  logic                  valid;
  logic [29:0]           word_idx;
  logic [WORD_BYTES-1:0] wr_be;

  always_comb begin
    live_req       = '0;
    live_req.we    = we;
    live_req.addr  = addr;
    live_req.wdata = wdata;
`ifdef MEM_RESP_BYTE_EN
    live_req.be    = be;
`endif
  end

  // With zero wait states the response edge is the accept edge, so the live inputs are used.
  assign req_d      = (state_q == IDLE) ? live_req : req_q;
  assign enter_resp = ((state_q == IDLE) && req && (WAIT_CYCLES == 0)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd1));

  // Full 30-bit index compare so high address bits never alias into the array.
  assign word_idx = req_d.addr[31:2];
  assign valid    = (req_d.addr[1:0] == 2'b00) && (word_idx < 30'(DEPTH));

`ifdef MEM_RESP_BYTE_EN
  assign wr_be = req_d.be;
`else
  assign wr_be = '1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= enter_resp;
      err_q   <= enter_resp && !valid;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            req_q   <= live_req;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  mem_resp_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk       (clk),
    .rst_n     (reset),
    .wr_en_i   (enter_resp && valid && req_d.we),
    .wr_be_i   (wr_be),
    .wr_data_i (req_d.wdata),
    .rd_en_i   (enter_resp && valid && !req_d.we),
    .rd_clr_i  (enter_resp && !valid),
    .idx_i     (word_idx[AW-1:0]),
    .rd_data_o (rdata)
  );

  assign ready = ready_q;
  assign err   = err_q;

endmodule
